// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back bus for the register file with its operand scoreboard.
// The master side (decode + write-back stages) drives requests. The slave side
// (the register file) returns the operands and the stall indication.
interface regfile_scoreboard_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 5
);
    logic                 rd_en;
    logic [ADDR_W-1:0]    rs_addr;
    logic [ADDR_W-1:0]    rt_addr;
    logic [WORD_SIZE-1:0] rs_data;
    logic [WORD_SIZE-1:0] rt_data;
    logic                 rd_valid;
    logic                 stall;
    logic                 issue_en;
    logic [ADDR_W-1:0]    issue_addr;
    logic                 wb_en;
    logic [ADDR_W-1:0]    wb_addr;
    logic [WORD_SIZE-1:0] wb_data;

    modport master (
        output rd_en, rs_addr, rt_addr, issue_en, issue_addr, wb_en, wb_addr, wb_data,
        input  rs_data, rt_data, rd_valid, stall
    );

    modport slave (
        input  rd_en, rs_addr, rt_addr, issue_en, issue_addr, wb_en, wb_addr, wb_data,
        output rs_data, rt_data, rd_valid, stall
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32-entry MIPS register file with two registered read ports (rs, rt).
// It bypasses write-back data to same-cycle reads. A per-register busy
// scoreboard stalls decode while an operand's producer is still outstanding.
module regfile_scoreboard #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic                 ready;
        logic [WORD_SIZE-1:0] value;
    } operand_t;

    logic [WORD_SIZE-1:0] regs_q [DEPTH];
    logic                 busy_q [DEPTH];

    logic [WORD_SIZE-1:0] rs_data_q, rs_data_d;
    logic [WORD_SIZE-1:0] rt_data_q, rt_data_d;
    logic                 rd_valid_q, rd_valid_d;

    operand_t rs_op, rt_op;
    logic     accept;

    // Resolve one source operand: r0 is zero, then write-back bypass, then
    // the scoreboard, and finally the stored value.
    function automatic operand_t resolve(input logic [ADDR_W-1:0] a);
        operand_t op;
        op.ready = 1'b1;
        op.value = '0;
        if (a == '0) begin
            op.value = '0;
        end else if (bus.wb_en && (bus.wb_addr == a)) begin
            op.value = bus.wb_data;
        end else if (busy_q[a]) begin
            op.ready = 1'b0;
        end else begin
            op.value = regs_q[a];
        end
        return op;
    endfunction

    // Operand resolution, stall, and the next state of the read port.
    always_comb begin
        rs_op      = resolve(bus.rs_addr);
        rt_op      = resolve(bus.rt_addr);
        bus.stall  = bus.rd_en && !(rs_op.ready && rt_op.ready);
        accept     = bus.rd_en && rs_op.ready && rt_op.ready;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        rd_valid_d = accept;
        if (accept) begin
            rs_data_d = rs_op.value;
            rt_data_d = rt_op.value;
        end
    end

    // Storage words and busy bits. Entry 0 is hard-wired to zero and never busy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        if (gi == 0) begin : g_zero
            // r0: constant zero, never claimed
            always_ff @(posedge clk or posedge rst) begin
                regs_q[gi] <= '0;
                busy_q[gi] <= 1'b0;
            end
        end else begin : g_reg
            // Write-enabled storage word, loaded on write-back to this index
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (bus.wb_en && (bus.wb_addr == ADDR_W'(gi))) begin
                    regs_q[gi] <= bus.wb_data;
                end
            end

            // Busy bit: an issue sets it and takes priority over a clearing write-back
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_q[gi] <= 1'b0;
                end else if (bus.issue_en && (bus.issue_addr == ADDR_W'(gi))) begin
                    busy_q[gi] <= 1'b1;
                end else if (bus.wb_en && (bus.wb_addr == ADDR_W'(gi))) begin
                    busy_q[gi] <= 1'b0;
                end
            end
        end
    end

    // Registered read port: one-cycle latency; the data holds when no read is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rs_data  = rs_data_q;
    assign bus.rt_data  = rt_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard. It runs directed vectors from a table and a
// hand-written asynchronous-reset sequence. It then runs random traffic that is
// checked against an array-based reference model.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.WORD_SIZE(32), .ADDR_W(5)) bus ();

    regfile_scoreboard #(.WORD_SIZE(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iss;
        logic [4:0]  ia;
        logic        wb;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int txn      = 0;

    vec_t tbl [17];

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] m_rs, m_rt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic [4:0] rs, input logic [4:0] rt,
                                input logic iss, input logic [4:0] ia,
                                input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                                input logic es, input logic ev,
                                input logic [31:0] ers, input logic [31:0] ert);
        vec_t v;
        v.rd = rd; v.rs = rs; v.rt = rt; v.iss = iss; v.ia = ia;
        v.wb = wb; v.wa = wa; v.wd = wd;
        v.e_stall = es; v.e_valid = ev; v.e_rs = ers; v.e_rt = ert;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.rd_en      = v.rd;
        bus.rs_addr    = v.rs;
        bus.rt_addr    = v.rt;
        bus.issue_en   = v.iss;
        bus.issue_addr = v.ia;
        bus.wb_en      = v.wb;
        bus.wb_addr    = v.wa;
        bus.wb_data    = v.wd;
    endtask

    // Drive at the falling edge, check stall before the rising edge, check outputs after it
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk("stall", 32'(bus.stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(bus.rd_valid), 32'(v.e_valid));
        chk("rs_data", bus.rs_data, v.e_rs);
        chk("rt_data", bus.rt_data, v.e_rt);
        $display("txn %0d rd=%0b rs=%0d rt=%0d iss=%0b/%0d wb=%0b/%0d stall=%0b valid=%0b rs_data=%h rt_data=%h",
                 txn, v.rd, v.rs, v.rt, v.iss, v.ia, v.wb, v.wa, bus.stall, bus.rd_valid,
                 bus.rs_data, bus.rt_data);
        txn++;
    endtask

    // Model: operand availability straight from the architectural rules
    function automatic void model_operand(input logic [4:0] a, input logic wb, input logic [4:0] wa,
                                          input logic [31:0] wd, output logic rdy, output logic [31:0] val);
        rdy = 1'b1;
        val = 32'h0;
        if (a != 0) begin
            if (wb && wa == a)  val = wd;
            else if (m_busy[a]) rdy = 1'b0;
            else                val = m_regs[a];
        end
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        // 17 directed steps, starting right after reset
        tbl[0]  = mk(1, 5, 0, 0, 0, 0, 0, 0,            0, 1, 32'h0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        tbl[2]  = mk(1, 7, 7, 0, 0, 0, 0, 0,            0, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[3]  = mk(1, 9, 0, 0, 0, 1, 9, 32'h12345678, 0, 1, 32'h12345678, 32'h0);
        tbl[4]  = mk(1, 9, 7, 0, 0, 0, 0, 0,            0, 1, 32'h12345678, 32'hDEADBEEF);
        tbl[5]  = mk(0, 0, 0, 1, 4, 0, 0, 0,            0, 0, 32'h12345678, 32'hDEADBEEF);
        tbl[6]  = mk(1, 0, 4, 0, 0, 0, 0, 0,            1, 0, 32'h12345678, 32'hDEADBEEF);
        tbl[7]  = mk(1, 0, 4, 0, 0, 0, 0, 0,            1, 0, 32'h12345678, 32'hDEADBEEF);
        tbl[8]  = mk(1, 0, 4, 0, 0, 0, 0, 0,            1, 0, 32'h12345678, 32'hDEADBEEF);
        tbl[9]  = mk(1, 0, 4, 0, 0, 1, 4, 32'hA5A5A5A5, 0, 1, 32'h0, 32'hA5A5A5A5);
        tbl[10] = mk(1, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 1, 32'h0, 32'h0);
        tbl[11] = mk(1, 0, 4, 0, 0, 0, 0, 0,            0, 1, 32'h0, 32'hA5A5A5A5);
        tbl[12] = mk(1, 3, 1, 1, 3, 0, 0, 0,            0, 1, 32'h0, 32'h0);
        tbl[13] = mk(1, 3, 9, 0, 0, 1, 3, 32'h33,       0, 1, 32'h33, 32'h12345678);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 1, 32'h11,       0, 0, 32'h33, 32'h12345678);
        tbl[15] = mk(1, 1, 3, 0, 0, 0, 0, 0,            0, 1, 32'h11, 32'h33);
        tbl[16] = mk(1, 1, 3, 1, 6, 1, 6, 32'h66,       0, 1, 32'h11, 32'h33);

        // Reset state
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset_valid", 32'(bus.rd_valid), 32'h0);
        chk("reset_rs", bus.rs_data, 32'h0);
        chk("reset_rt", bus.rt_data, 32'h0);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // r6 was issued and written back in the same cycle, so it stays busy.
        // An asynchronous reset in the middle of the stalled cycle clears everything.
        @(negedge clk);
        drive(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("r6_busy_stall", 32'(bus.stall), 32'h1);
        chk("pre_rst_valid", 32'(bus.rd_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(bus.stall), 32'h0);
        chk("async_rst_valid", 32'(bus.rd_valid), 32'h0);
        chk("async_rst_rs", bus.rs_data, 32'h0);
        chk("async_rst_rt", bus.rt_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 6, 7, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0));

        // Random traffic against the model (state matches the post-reset DUT)
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_rs = 32'h0;
        m_rt = 32'h0;
        for (int i = 0; i < 400; i++) begin
            logic rs_rdy, rt_rdy, stl;
            logic [31:0] rs_v, rt_v;
            v.rd  = 1'($urandom_range(0, 3) != 0);
            v.rs  = 5'($urandom_range(0, 7));
            v.rt  = 5'($urandom_range(0, 7));
            v.wb  = 1'($urandom_range(0, 1));
            v.wa  = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.ia  = 5'($urandom_range(0, 7));
            model_operand(v.rs, v.wb, v.wa, v.wd, rs_rdy, rs_v);
            model_operand(v.rt, v.wb, v.wa, v.wd, rt_rdy, rt_v);
            stl   = v.rd && !(rs_rdy && rt_rdy);
            // Instructions are never issued while decode is stalled
            v.iss = !stl && ($urandom_range(0, 2) == 0);
            if (v.rd && !stl) begin
                m_rs = rs_v;
                m_rt = rt_v;
            end
            v.e_stall = stl;
            v.e_valid = v.rd && !stl;
            v.e_rs    = m_rs;
            v.e_rt    = m_rt;
            apply(v);
            if (v.wb && v.wa != 0) begin
                m_regs[v.wa] = v.wd;
                m_busy[v.wa] = 1'b0;
            end
            if (v.iss && v.ia != 0) m_busy[v.ia] = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
